// File: rtl/esc_run_sequencer_if.sv
// Signal bundle between the ESC run sequencer and its surroundings: operator
// requests and ESC feedback in, ESC drive and status out.
interface esc_run_sequencer_if #(
    parameter int DATA_WIDTH = 16
);
    logic                  start;
    logic                  stop;
    logic                  clear_fault;
    logic [DATA_WIDTH-1:0] target_period;
    logic [DATA_WIDTH-1:0] period_speed;
    logic                  tuning_done;
    logic                  pwm_en;
    logic [DATA_WIDTH-1:0] period_reference;
    logic                  tuner_reset;
    logic                  override_internal_pid;
    logic                  fault;
    logic [2:0]            state;

    modport master (
        input  start, stop, clear_fault, target_period, period_speed, tuning_done,
        output pwm_en, period_reference, tuner_reset, override_internal_pid, fault, state
    );

    modport slave (
        output start, stop, clear_fault, target_period, period_speed, tuning_done,
        input  pwm_en, period_reference, tuner_reset, override_internal_pid, fault, state
    );
endinterface

// File: rtl/esc_run_sequencer.sv
// Start-up sequencer for the BLDC ESC: idle, align, soft-start ramp, closed-loop
// run, brake and a latched stall fault driven by a speed-change watchdog.
module esc_run_sequencer #(
    parameter int                    DATA_WIDTH   = 16,
    parameter int                    CNT_WIDTH    = 24,
    parameter logic [DATA_WIDTH-1:0] START_PERIOD = 16'h4000,
    parameter int                    ALIGN_CYCLES = 1000,
    parameter int                    RAMP_DIV     = 256,
    parameter int                    RAMP_STEP    = 16,
    parameter int                    BRAKE_CYCLES = 2000,
    parameter logic [CNT_WIDTH-1:0]  STALL_CYCLES = 24'd1000000
) (
    input logic                 clk,
    input logic                 reset,
    esc_run_sequencer_if.master bus
);
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ALIGN = 3'd1,
        RAMP  = 3'd2,
        RUN   = 3'd3,
        BRAKE = 3'd4,
        FAULT = 3'd5
    } state_t;

    localparam logic [CNT_WIDTH-1:0]  CNT_ONE    = 1;
    localparam logic [CNT_WIDTH-1:0]  ALIGN_LAST = CNT_WIDTH'(ALIGN_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0]  RAMP_LAST  = CNT_WIDTH'(RAMP_DIV - 1);
    localparam logic [CNT_WIDTH-1:0]  BRAKE_LAST = CNT_WIDTH'(BRAKE_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0]  STALL_LAST = STALL_CYCLES - CNT_ONE;
    localparam logic [DATA_WIDTH-1:0] STEP       = DATA_WIDTH'(RAMP_STEP);
    localparam logic [DATA_WIDTH:0]   STEP_WIDE  = (DATA_WIDTH + 1)'(RAMP_STEP);

    state_t                fsm_state;
    logic [CNT_WIDTH-1:0]  timer;
    logic [CNT_WIDTH-1:0]  stall_timer;
    logic [DATA_WIDTH-1:0] period_ref;
    logic [DATA_WIDTH-1:0] speed_prev;
    logic                  pwm_reg;
    logic                  tuner_reg;
    logic                  opid_reg;
    logic                  fault_reg;

    logic target_valid;
    logic speed_changed;
    logic watching;
    logic stall_hit;
    logic step_reaches;

    // The step test is done one bit wider so a reference near zero never wraps.
    always_comb begin
        target_valid  = (bus.target_period != '0) && !bus.target_period[DATA_WIDTH-1]
                        && (bus.target_period <= START_PERIOD);
        speed_changed = (bus.period_speed != speed_prev);
        watching      = (fsm_state == RAMP) || (fsm_state == RUN);
        stall_hit     = watching && !speed_changed && (stall_timer == STALL_LAST);
        step_reaches  = {1'b0, period_ref} <= ({1'b0, bus.target_period} + STEP_WIDE);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            fsm_state   <= IDLE;
            timer       <= '0;
            stall_timer <= '0;
            period_ref  <= START_PERIOD;
            speed_prev  <= '0;
            pwm_reg     <= 1'b0;
            tuner_reg   <= 1'b0;
            opid_reg    <= 1'b1;
            fault_reg   <= 1'b0;
        end else begin
            speed_prev <= bus.period_speed;
            if (watching) begin
                stall_timer <= speed_changed ? '0 : stall_timer + CNT_ONE;
            end else begin
                stall_timer <= '0;
            end

            case (fsm_state)
                IDLE: begin
                    pwm_reg    <= 1'b0;
                    tuner_reg  <= 1'b0;
                    opid_reg   <= 1'b1;
                    period_ref <= START_PERIOD;
                    timer      <= '0;
                    if (bus.start && !bus.stop && target_valid) begin
                        fsm_state <= ALIGN;
                        pwm_reg   <= 1'b1;
                        tuner_reg <= 1'b1;
                    end
                end
                ALIGN: begin
                    if (bus.stop) begin
                        fsm_state  <= BRAKE;
                        pwm_reg    <= 1'b0;
                        tuner_reg  <= 1'b0;
                        period_ref <= START_PERIOD;
                        timer      <= '0;
                    end else if (timer == ALIGN_LAST) begin
                        fsm_state <= RAMP;
                        tuner_reg <= 1'b0;
                        timer     <= '0;
                    end else begin
                        timer <= timer + CNT_ONE;
                    end
                end
                RAMP: begin
                    if (stall_hit) begin
                        fsm_state  <= FAULT;
                        pwm_reg    <= 1'b0;
                        fault_reg  <= 1'b1;
                        period_ref <= START_PERIOD;
                        timer      <= '0;
                    end else if (bus.stop) begin
                        fsm_state  <= BRAKE;
                        pwm_reg    <= 1'b0;
                        period_ref <= START_PERIOD;
                        timer      <= '0;
                    end else if (bus.target_period >= period_ref) begin
                        fsm_state  <= RUN;
                        period_ref <= bus.target_period;
                        opid_reg   <= ~bus.tuning_done;
                        timer      <= '0;
                    end else if (timer == RAMP_LAST) begin
                        timer <= '0;
                        if (step_reaches) begin
                            fsm_state  <= RUN;
                            period_ref <= bus.target_period;
                            opid_reg   <= ~bus.tuning_done;
                        end else begin
                            period_ref <= period_ref - STEP;
                        end
                    end else begin
                        timer <= timer + CNT_ONE;
                    end
                end
                RUN: begin
                    if (stall_hit) begin
                        fsm_state  <= FAULT;
                        pwm_reg    <= 1'b0;
                        fault_reg  <= 1'b1;
                        opid_reg   <= 1'b1;
                        period_ref <= START_PERIOD;
                        timer      <= '0;
                    end else if (bus.stop || !target_valid) begin
                        fsm_state  <= BRAKE;
                        pwm_reg    <= 1'b0;
                        opid_reg   <= 1'b1;
                        period_ref <= START_PERIOD;
                        timer      <= '0;
                    end else if (bus.target_period > period_ref) begin
                        period_ref <= bus.target_period;
                        opid_reg   <= ~bus.tuning_done;
                    end else if (bus.target_period < period_ref) begin
                        // Speeding up re-enters the ramp from the present reference.
                        fsm_state   <= RAMP;
                        opid_reg    <= 1'b1;
                        timer       <= '0;
                        stall_timer <= '0;
                    end else begin
                        opid_reg <= ~bus.tuning_done;
                    end
                end
                BRAKE: begin
                    if (timer == BRAKE_LAST) begin
                        fsm_state <= IDLE;
                        timer     <= '0;
                    end else begin
                        timer <= timer + CNT_ONE;
                    end
                end
                FAULT: begin
                    if (bus.clear_fault && !bus.start) begin
                        fsm_state <= IDLE;
                        fault_reg <= 1'b0;
                    end
                end
                default: begin
                    fsm_state  <= IDLE;
                    pwm_reg    <= 1'b0;
                    tuner_reg  <= 1'b0;
                    opid_reg   <= 1'b1;
                    period_ref <= START_PERIOD;
                    timer      <= '0;
                end
            endcase
        end
    end

    assign bus.state                 = fsm_state;
    assign bus.pwm_en                = pwm_reg;
    assign bus.period_reference      = period_ref;
    assign bus.tuner_reset           = tuner_reg;
    assign bus.override_internal_pid = opid_reg;
    assign bus.fault                 = fault_reg;
endmodule

// File: tb/tb_esc_run_sequencer.sv
// Directed bench for esc_run_sequencer with a scaled-down parameter set: a vector
// table for the main start/ramp/run/brake flow plus stall, fault and reset sequences.
module tb_esc_run_sequencer;
    localparam int DW = 16;
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ALIGN = 3'd1;
    localparam logic [2:0] S_RAMP  = 3'd2;
    localparam logic [2:0] S_RUN   = 3'd3;
    localparam logic [2:0] S_BRAKE = 3'd4;
    localparam logic [2:0] S_FAULT = 3'd5;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          toggle_en = 1'b1;
    logic [DW-1:0] speed = 16'h1234;
    int            tests_run = 0;
    int            tests_failed = 0;

    esc_run_sequencer_if #(.DATA_WIDTH(DW)) bus ();
    assign bus.period_speed = speed;

    esc_run_sequencer #(
        .DATA_WIDTH(DW), .CNT_WIDTH(24), .START_PERIOD(16'd100), .ALIGN_CYCLES(10),
        .RAMP_DIV(4), .RAMP_STEP(10), .BRAKE_CYCLES(5), .STALL_CYCLES(24'd50)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // A moving speed keeps the watchdog quiet until a test freezes it.
    always @(negedge clk) begin
        if (toggle_en) speed = speed + 16'd1;
    end

    typedef struct {
        logic          start, stop, clr;
        logic [DW-1:0] target;
        logic          td;
        int            adv;
        logic [2:0]    st;
        logic          pwm;
        logic [DW-1:0] rf;
        logic          tun, opid, flt;
    } vec_t;

    vec_t vecs[$];

    task automatic addVec(input logic s, sp, c, input logic [DW-1:0] t, input logic d,
                          input int a, input logic [2:0] es, input logic ep,
                          input logic [DW-1:0] er, input logic et, eo, ef);
        vec_t v;
        v.start = s; v.stop = sp; v.clr = c; v.target = t; v.td = d; v.adv = a;
        v.st = es; v.pwm = ep; v.rf = er; v.tun = et; v.opid = eo; v.flt = ef;
        vecs.push_back(v);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic applyStimulus(input logic s, sp, c, input logic [DW-1:0] t, input logic d);
        bus.start = s;
        bus.stop = sp;
        bus.clear_fault = c;
        bus.target_period = t;
        bus.tuning_done = d;
    endtask

    task automatic checkOne(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic checkOutput(input string tag, input logic [2:0] es, input logic ep,
                               input logic [DW-1:0] er, input logic et, eo, ef);
        checkOne({tag, " state"}, DW'(bus.state), DW'(es));
        checkOne({tag, " pwm_en"}, DW'(bus.pwm_en), DW'(ep));
        checkOne({tag, " period_reference"}, bus.period_reference, er);
        checkOne({tag, " tuner_reset"}, DW'(bus.tuner_reset), DW'(et));
        checkOne({tag, " override_internal_pid"}, DW'(bus.override_internal_pid), DW'(eo));
        checkOne({tag, " fault"}, DW'(bus.fault), DW'(ef));
    endtask

    initial begin
        applyStimulus(1'b0, 1'b0, 1'b0, 16'd60, 1'b0);
        reset = 1'b0;
        step(3);
        checkOutput("reset", S_IDLE, 1'b0, 16'd100, 1'b0, 1'b1, 1'b0);
        reset = 1'b1;
        step(1);
        checkOutput("idle", S_IDLE, 1'b0, 16'd100, 1'b0, 1'b1, 1'b0);

        // Normal start: align 10 cycles, ramp 90/80/70 then 60 in RUN
        addVec(1, 0, 0, 16'd60, 0, 1, S_ALIGN, 1, 16'd100, 1, 1, 0);
        addVec(1, 0, 0, 16'd60, 0, 9, S_ALIGN, 1, 16'd100, 1, 1, 0);
        addVec(1, 0, 0, 16'd60, 0, 1, S_RAMP, 1, 16'd100, 0, 1, 0);
        addVec(1, 0, 0, 16'd60, 0, 3, S_RAMP, 1, 16'd100, 0, 1, 0);
        addVec(1, 0, 0, 16'd60, 0, 1, S_RAMP, 1, 16'd90, 0, 1, 0);
        addVec(1, 0, 0, 16'd60, 0, 4, S_RAMP, 1, 16'd80, 0, 1, 0);
        addVec(1, 0, 0, 16'd60, 0, 4, S_RAMP, 1, 16'd70, 0, 1, 0);
        addVec(1, 0, 0, 16'd60, 0, 4, S_RUN, 1, 16'd60, 0, 1, 0);
        // Retarget in RUN: slower is immediate, faster ramps 70/60/50/40
        addVec(1, 0, 0, 16'd80, 0, 1, S_RUN, 1, 16'd80, 0, 1, 0);
        addVec(1, 0, 0, 16'd80, 1, 1, S_RUN, 1, 16'd80, 0, 0, 0);
        addVec(1, 0, 0, 16'd40, 1, 1, S_RAMP, 1, 16'd80, 0, 1, 0);
        addVec(1, 0, 0, 16'd40, 1, 4, S_RAMP, 1, 16'd70, 0, 1, 0);
        addVec(1, 0, 0, 16'd40, 1, 4, S_RAMP, 1, 16'd60, 0, 1, 0);
        addVec(1, 0, 0, 16'd40, 1, 4, S_RAMP, 1, 16'd50, 0, 1, 0);
        addVec(1, 0, 0, 16'd40, 1, 4, S_RUN, 1, 16'd40, 0, 0, 0);
        // Stop mid-ramp, brake 5 cycles with start held, then restart and abort align
        addVec(1, 0, 0, 16'd10, 0, 1, S_RAMP, 1, 16'd40, 0, 1, 0);
        addVec(1, 0, 0, 16'd10, 0, 4, S_RAMP, 1, 16'd30, 0, 1, 0);
        addVec(1, 1, 0, 16'd10, 0, 1, S_BRAKE, 0, 16'd100, 0, 1, 0);
        addVec(1, 0, 0, 16'd60, 0, 4, S_BRAKE, 0, 16'd100, 0, 1, 0);
        addVec(1, 0, 0, 16'd60, 0, 1, S_IDLE, 0, 16'd100, 0, 1, 0);
        addVec(1, 0, 0, 16'd60, 0, 1, S_ALIGN, 1, 16'd100, 1, 1, 0);
        addVec(1, 1, 0, 16'd60, 0, 1, S_BRAKE, 0, 16'd100, 0, 1, 0);
        addVec(0, 0, 0, 16'd60, 0, 5, S_IDLE, 0, 16'd100, 0, 1, 0);
        // Clamp: first step loads 95 directly
        addVec(1, 0, 0, 16'd95, 0, 1, S_ALIGN, 1, 16'd100, 1, 1, 0);
        addVec(1, 0, 0, 16'd95, 0, 10, S_RAMP, 1, 16'd100, 0, 1, 0);
        addVec(1, 0, 0, 16'd95, 0, 3, S_RAMP, 1, 16'd100, 0, 1, 0);
        addVec(1, 0, 0, 16'd95, 0, 1, S_RUN, 1, 16'd95, 0, 1, 0);
        addVec(1, 0, 0, 16'd95, 0, 2, S_RUN, 1, 16'd95, 0, 1, 0);
        // Invalid target in RUN acts as stop
        addVec(0, 0, 0, 16'h8000, 0, 1, S_BRAKE, 0, 16'd100, 0, 1, 0);
        addVec(0, 0, 0, 16'd60, 0, 5, S_IDLE, 0, 16'd100, 0, 1, 0);
        // Invalid targets and stop+start in IDLE
        addVec(1, 0, 0, 16'h8000, 0, 3, S_IDLE, 0, 16'd100, 0, 1, 0);
        addVec(1, 0, 0, 16'd0, 0, 2, S_IDLE, 0, 16'd100, 0, 1, 0);
        addVec(1, 0, 0, 16'd101, 0, 2, S_IDLE, 0, 16'd100, 0, 1, 0);
        addVec(1, 1, 0, 16'd60, 0, 2, S_IDLE, 0, 16'd100, 0, 1, 0);
        // Target equal to START_PERIOD: valid, and RAMP hands over to RUN at once
        addVec(1, 0, 0, 16'd100, 0, 1, S_ALIGN, 1, 16'd100, 1, 1, 0);
        addVec(1, 0, 0, 16'd100, 0, 10, S_RAMP, 1, 16'd100, 0, 1, 0);
        addVec(1, 0, 0, 16'd100, 0, 1, S_RUN, 1, 16'd100, 0, 1, 0);
        addVec(0, 1, 0, 16'd100, 0, 1, S_BRAKE, 0, 16'd100, 0, 1, 0);
        addVec(0, 0, 0, 16'd100, 0, 5, S_IDLE, 0, 16'd100, 0, 1, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].start, vecs[i].stop, vecs[i].clr, vecs[i].target, vecs[i].td);
            step(vecs[i].adv);
            checkOutput($sformatf("vec%0d", i), vecs[i].st, vecs[i].pwm, vecs[i].rf,
                        vecs[i].tun, vecs[i].opid, vecs[i].flt);
        end

        // Stall in RUN; the fault edge also carries stop, and the fault must win
        applyStimulus(1'b1, 1'b0, 1'b0, 16'd60, 1'b0);
        step(11);
        checkOutput("stall ramp", S_RAMP, 1'b1, 16'd100, 1'b0, 1'b1, 1'b0);
        step(16);
        checkOutput("stall run", S_RUN, 1'b1, 16'd60, 1'b0, 1'b1, 1'b0);
        toggle_en = 1'b0;
        step(49);
        checkOutput("stall pre", S_RUN, 1'b1, 16'd60, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, 16'd60, 1'b0);
        step(1);
        checkOutput("stall hit", S_FAULT, 1'b0, 16'd100, 1'b0, 1'b1, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b1, 16'd60, 1'b0);
        step(2);
        checkOutput("clear with start", S_FAULT, 1'b0, 16'd100, 1'b0, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1, 16'd60, 1'b0);
        step(1);
        checkOutput("clear", S_IDLE, 1'b0, 16'd100, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 16'd60, 1'b0);

        // Reset mid-RUN, then reset with the fault latched
        toggle_en = 1'b1;
        applyStimulus(1'b1, 1'b0, 1'b0, 16'd60, 1'b0);
        step(27);
        checkOutput("run again", S_RUN, 1'b1, 16'd60, 1'b0, 1'b1, 1'b0);
        reset = 1'b0;
        step(1);
        checkOutput("reset in run", S_IDLE, 1'b0, 16'd100, 1'b0, 1'b1, 1'b0);
        reset = 1'b1;
        toggle_en = 1'b0;
        step(60);
        checkOutput("stall run2", S_RUN, 1'b1, 16'd60, 1'b0, 1'b1, 1'b0);
        step(1);
        checkOutput("stall hit2", S_FAULT, 1'b0, 16'd100, 1'b0, 1'b1, 1'b1);
        reset = 1'b0;
        step(1);
        checkOutput("reset in fault", S_IDLE, 1'b0, 16'd100, 1'b0, 1'b1, 1'b0);
        reset = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, 16'd60, 1'b0);
        step(2);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
